// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed 7-segment scanner: one registered digit slot per scan tick,
// with per-digit dp/blank/blink. Optional macro LEADING_ZERO_SUPPRESS_EN darkens leading zeros.
module seven_seg_scanner #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV_BITS  = 16,
  parameter int BLINK_DIV_BITS = 25,
  localparam int IDXW          = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] nums,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic [N_DIGITS-1:0]   blink,
  output logic [6:0]            display,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   digit,
  output logic [IDXW-1:0]       scan_idx,
  output logic                  frame_done
);

  logic [SCAN_DIV_BITS-1:0]  scan_cnt;
  logic [BLINK_DIV_BITS-1:0] blink_cnt;
  logic                      tick;
  logic                      blink_phase;
  logic [N_DIGITS-1:0][3:0]  codes;
  logic [N_DIGITS-1:0]       lz;
  logic [IDXW-1:0]           next_idx;
  logic [3:0]                sel_code;
  logic                      sel_dark;

  assign codes       = nums;
  assign tick        = &scan_cnt;
  assign blink_phase = blink_cnt[BLINK_DIV_BITS-1];
  assign next_idx    = (scan_idx == IDXW'(N_DIGITS-1)) ? '0 : scan_idx + IDXW'(1);
  assign sel_code    = codes[next_idx];
  assign sel_dark    = blank[next_idx] | (blink[next_idx] & blink_phase) | lz[next_idx];

`ifdef LEADING_ZERO_SUPPRESS_EN
  // Running AND from the top digit down; digit 0 is never part of the chain.
  logic zero_above;
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS-1; i > 0; i--) begin
      zero_above = zero_above & (codes[i] == 4'd0);
      lz[i]      = zero_above;
    end
  end
`else
  assign lz = '0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'd0:  seg7 = 7'b1000000;
      4'd1:  seg7 = 7'b1111001;
      4'd2:  seg7 = 7'b0100100;
      4'd3:  seg7 = 7'b0110000;
      4'd4:  seg7 = 7'b0011001;
      4'd5:  seg7 = 7'b0010010;
      4'd6:  seg7 = 7'b0000010;
      4'd7:  seg7 = 7'b1111000;
      4'd8:  seg7 = 7'b0000000;
      4'd9:  seg7 = 7'b0010000;
      4'd10: seg7 = 7'b0010010;
      4'd11: seg7 = 7'b0001100;
      4'd12: seg7 = 7'b0001000;
      4'd13: seg7 = 7'b0111111;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt   <= '0;
      blink_cnt  <= '0;
      display    <= 7'h7F;
      dp         <= 1'b1;
      digit      <= '1;
      scan_idx   <= IDXW'(N_DIGITS-1);
      frame_done <= 1'b0;
    end else begin
      scan_cnt   <= scan_cnt + SCAN_DIV_BITS'(1);
      blink_cnt  <= blink_cnt + BLINK_DIV_BITS'(1);
      frame_done <= 1'b0;
      if (tick) begin
        if (en) begin
          // Dark digits keep their anode low so slot timing stays uniform.
          scan_idx   <= next_idx;
          digit      <= ~(N_DIGITS'(1) << next_idx);
          display    <= sel_dark ? 7'h7F : seg7(sel_code);
          dp         <= sel_dark | ~dp_in[next_idx];
          frame_done <= (next_idx == '0);
        end else begin
          digit   <= '1;
          display <= 7'h7F;
          dp      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed table-driven bench for seven_seg_scanner (N=4, scan tick every 4 clks, blink period 16).
module tb_seven_seg_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] nums = '0;
  logic [3:0]  dp_in = '0, blank = '0, blink = '0;
  logic [6:0]  display;
  logic        dp;
  logic [3:0]  digit;
  logic [1:0]  scan_idx;
  logic        frame_done;
  int          npass = 0, ntot = 0;

  seven_seg_scanner #(.N_DIGITS(4), .SCAN_DIV_BITS(2), .BLINK_DIV_BITS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .nums(nums), .dp_in(dp_in), .blank(blank),
    .blink(blink), .display(display), .dp(dp), .digit(digit), .scan_idx(scan_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] nums;
    logic [3:0]  dp_in, blank, blink;
    logic [3:0]  e_digit;
    logic [6:0]  e_disp;
    logic        e_dp;
    logic [1:0]  e_idx;
    logic        e_fd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got digit/disp/dp/idx/fd=%b required %b", name, act, exp);
  endtask

  function automatic logic [14:0] outs();
    return {digit, display, dp, scan_idx, frame_done};
  endfunction

  task automatic tick_check(input string name, input logic [3:0] d, input logic [6:0] s,
                            input logic p, input logic [1:0] i, input logic f);
    @(negedge clk);
    ntot++;
    if (frame_done === 1'b0) npass++;
    else $display("FAIL %s_mid: frame_done=%b required 0", name, frame_done);
    repeat (3) @(negedge clk);
    chk(name, outs(), {d, s, p, i, f});
  endtask

  initial begin
    // edge e = 4k; blink counter before edge e is (e-1)%16, dark phase when >= 8
    tbl.push_back('{1, 16'h1234, 4'h0, 4'h0, 4'h0, 4'b1110, 7'b0011001, 1, 2'd0, 1});
    tbl.push_back('{1, 16'h1234, 4'h0, 4'h0, 4'h0, 4'b1101, 7'b0110000, 1, 2'd1, 0});
    tbl.push_back('{1, 16'h1234, 4'h0, 4'h0, 4'h0, 4'b1011, 7'b0100100, 1, 2'd2, 0});
    tbl.push_back('{1, 16'h1234, 4'h0, 4'h0, 4'h0, 4'b0111, 7'b1111001, 1, 2'd3, 0});
    tbl.push_back('{1, 16'h1234, 4'h0, 4'h0, 4'h0, 4'b1110, 7'b0011001, 1, 2'd0, 1});
    tbl.push_back('{1, 16'hABCD, 4'h0, 4'h0, 4'h0, 4'b1101, 7'b0001000, 1, 2'd1, 0});
    tbl.push_back('{1, 16'hABCD, 4'h0, 4'h0, 4'h0, 4'b1011, 7'b0001100, 1, 2'd2, 0});
    tbl.push_back('{1, 16'hABCD, 4'h0, 4'h0, 4'h0, 4'b0111, 7'b0010010, 1, 2'd3, 0});
    tbl.push_back('{1, 16'hABCD, 4'h0, 4'h0, 4'h0, 4'b1110, 7'b0111111, 1, 2'd0, 1});
    tbl.push_back('{1, 16'h00FE, 4'h0, 4'h0, 4'h0, 4'b1101, 7'b1111111, 1, 2'd1, 0});
`ifdef LEADING_ZERO_SUPPRESS_EN
    tbl.push_back('{1, 16'h00FE, 4'h0, 4'h0, 4'h0, 4'b1011, 7'b1111111, 1, 2'd2, 0});
    tbl.push_back('{1, 16'h00FE, 4'h0, 4'h0, 4'h0, 4'b0111, 7'b1111111, 1, 2'd3, 0});
`else
    tbl.push_back('{1, 16'h00FE, 4'h0, 4'h0, 4'h0, 4'b1011, 7'b1000000, 1, 2'd2, 0});
    tbl.push_back('{1, 16'h00FE, 4'h0, 4'h0, 4'h0, 4'b0111, 7'b1000000, 1, 2'd3, 0});
`endif
    tbl.push_back('{1, 16'h00FE, 4'h0, 4'h0, 4'h0, 4'b1110, 7'b1111111, 1, 2'd0, 1});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0010, 4'h0, 4'b1101, 7'b1111111, 1, 2'd1, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0010, 4'h0, 4'b1011, 7'b0000010, 1, 2'd2, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0010, 4'h0, 4'b0111, 7'b0010010, 1, 2'd3, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0010, 4'h0, 4'b1110, 7'b0000000, 1, 2'd0, 1});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'h0, 4'b1101, 7'b1111000, 0, 2'd1, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'hF, 4'b1011, 7'b1111111, 1, 2'd2, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'hF, 4'b0111, 7'b1111111, 1, 2'd3, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'hF, 4'b1110, 7'b0000000, 1, 2'd0, 1});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'hF, 4'b1101, 7'b1111000, 0, 2'd1, 0});
    tbl.push_back('{0, 16'h5678, 4'b0010, 4'b0000, 4'h0, 4'b1111, 7'b1111111, 1, 2'd1, 0});
    tbl.push_back('{0, 16'h5678, 4'b0010, 4'b0000, 4'h0, 4'b1111, 7'b1111111, 1, 2'd1, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'h0, 4'b1011, 7'b0000010, 1, 2'd2, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'b0001, 4'b0111, 7'b0010010, 1, 2'd3, 0});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'b0001, 4'b1110, 7'b1111111, 1, 2'd0, 1});
    tbl.push_back('{1, 16'h5678, 4'b0010, 4'b0000, 4'b0001, 4'b1101, 7'b1111000, 0, 2'd1, 0});

    repeat (2) @(negedge clk);
    chk("reset", outs(), {4'b1111, 7'h7F, 1'b1, 2'd3, 1'b0});
    rst = 1'b0;
    for (int k = 0; k < tbl.size(); k++) begin
      en = tbl[k].en; nums = tbl[k].nums; dp_in = tbl[k].dp_in;
      blank = tbl[k].blank; blink = tbl[k].blink;
      tick_check($sformatf("vec%0d", k), tbl[k].e_digit, tbl[k].e_disp, tbl[k].e_dp,
                 tbl[k].e_idx, tbl[k].e_fd);
    end

    // Asynchronous reset mid-slot, away from any clock edge
    blink = '0; en = 1'b1;
    @(negedge clk); #2 rst = 1'b1;
    #1 chk("async_rst", outs(), {4'b1111, 7'h7F, 1'b1, 2'd3, 1'b0});
    @(negedge clk); rst = 1'b0;
    tick_check("restart", 4'b1110, 7'b0000000, 1'b1, 2'd0, 1'b1);

`ifdef LEADING_ZERO_SUPPRESS_EN
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0; nums = 16'h0050; dp_in = 4'b1100;
    tick_check("lz0", 4'b1110, 7'b1000000, 1'b1, 2'd0, 1'b1);
    tick_check("lz1", 4'b1101, 7'b0010010, 1'b1, 2'd1, 1'b0);
    tick_check("lz2", 4'b1011, 7'b1111111, 1'b1, 2'd2, 1'b0);
    tick_check("lz3", 4'b0111, 7'b1111111, 1'b1, 2'd3, 1'b0);
    nums = 16'h0000;
    tick_check("lz_all0_d0", 4'b1110, 7'b1000000, 1'b1, 2'd0, 1'b1);
    tick_check("lz_all0_d1", 4'b1101, 7'b1111111, 1'b1, 2'd1, 1'b0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
